// File: rtl/data_bus_unit.sv
// rtl/data_bus_unit.sv - registered load/store bus master with wait states
//
// Purpose: runs one bus cycle per core request (IDLE -> BUS -> DONE), holding
// the core via o_stall, placing store data on byte lanes and extracting and
// extending load data. Misaligned requests finish with o_err and no bus cycle.
// Optional macro DBU_TIMEOUT_EN: abort a bus cycle after TIMEOUT unacked
// wait cycles and report it through o_err.
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   i_req/i_write/i_size/i_signed/i_addr/i_wdata   core request
//   o_stall/o_done/o_err/o_rdata                   core response
//   DAD/MREQ/WRITE/SIZE  bus address and control outputs
//   ACKD_n               bus acknowledge, active-low
//   DDT                  bidirectional bus data, driven only while MREQ & WRITE
module data_bus_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic              i_write,
  input  logic [1:0]        i_size,
  input  logic              i_signed,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_stall,
  output logic              o_done,
  output logic              o_err,
  output logic [DATA_W-1:0] o_rdata,
  output logic [ADDR_W-1:0] DAD,
  output logic              MREQ,
  output logic              WRITE,
  output logic [1:0]        SIZE,
  input  logic              ACKD_n,
  inout  wire  [DATA_W-1:0] DDT
);

  localparam int LW = $clog2(DATA_W / 8);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

  state_t            state, state_nx;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              signed_q;
  logic              err_q;
  logic              misaligned;
  logic              ack;
  logic              timeout;
  logic [DATA_W-1:0] lane_wdata;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] keep;
  logic              sign_bit;
  logic [DATA_W-1:0] load_ext;

  assign ack     = (state == S_BUS) && !ACKD_n;
  assign o_stall = ((state == S_IDLE) && i_req) || (state == S_BUS);
  assign o_done  = (state == S_DONE);
  assign o_err   = (state == S_DONE) && err_q;
  assign o_rdata = rdata_q;
  assign DDT     = (MREQ && WRITE) ? wdata_q : {DATA_W{1'bz}};

  // A dword access is never legal on a 32-bit bus.
  always_comb begin
    misaligned = 1'b0;
    case (i_size)
      2'b00:   misaligned = (i_addr[1:0] != 2'b00);
      2'b01:   misaligned = i_addr[0];
      2'b10:   misaligned = 1'b0;
      default: misaligned = (DATA_W == 32) || (i_addr[2:0] != 3'b000);
    endcase
  end

  // Stores replicate the operand across every lane of its size so the
  // target lane is correct whatever the low address bits are.
  always_comb begin
    lane_wdata = i_wdata;
    case (i_size)
      2'b10:   lane_wdata = {(DATA_W / 8){i_wdata[7:0]}};
      2'b01:   lane_wdata = {(DATA_W / 16){i_wdata[15:0]}};
      2'b00:   lane_wdata = {(DATA_W / 32){i_wdata[31:0]}};
      default: lane_wdata = i_wdata;
    endcase
  end

  // Loads: shift the addressed lane down to bit 0, mask to the access size
  // and fill the upper bits with the lane's sign when sign extension is on.
  assign shifted = DDT >> {DAD[LW-1:0], 3'b000};

  always_comb begin
    keep     = '1;
    sign_bit = 1'b0;
    case (SIZE)
      2'b10: begin
        keep     = DATA_W'(8'hFF);
        sign_bit = shifted[7];
      end
      2'b01: begin
        keep     = DATA_W'(16'hFFFF);
        sign_bit = shifted[15];
      end
      2'b00: begin
        keep     = DATA_W'(32'hFFFF_FFFF);
        sign_bit = shifted[31];
      end
      default: begin
        keep     = '1;
        sign_bit = 1'b0;
      end
    endcase
    load_ext = (shifted & keep) | ((signed_q && sign_bit) ? ~keep : '0);
  end

`ifdef DBU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (state != S_BUS) begin
      wait_cnt <= '0;
    end else if (ACKD_n) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

  // Fires on the cycle that would complete the TIMEOUT-th unacked wait.
  assign timeout = (state == S_BUS) && ACKD_n && (wait_cnt == CW'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign timeout        = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (i_req) state_nx = misaligned ? S_DONE : S_BUS;
      S_BUS:   if (ack || timeout) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      DAD      <= '0;
      SIZE     <= 2'b00;
      WRITE    <= 1'b0;
      MREQ     <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_req) begin
            err_q   <= misaligned;
            rdata_q <= '0;
            if (!misaligned) begin
              DAD      <= i_addr;
              SIZE     <= i_size;
              WRITE    <= i_write;
              MREQ     <= 1'b1;
              wdata_q  <= lane_wdata;
              signed_q <= i_signed;
            end
          end
        end
        S_BUS: begin
          // Ack takes priority over a timeout reached in the same cycle.
          if (ack) begin
            rdata_q <= load_ext;
            MREQ    <= 1'b0;
            WRITE   <= 1'b0;
          end else if (timeout) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            MREQ    <= 1'b0;
            WRITE   <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_bus_unit.sv
// tb/tb_data_bus_unit.sv - directed self-checking bench for data_bus_unit
module tb_data_bus_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic        i_write;
  logic [1:0]  i_size;
  logic        i_signed;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  wire         o_stall;
  wire         o_done;
  wire         o_err;
  wire  [31:0] o_rdata;
  wire  [31:0] DAD;
  wire         MREQ;
  wire         WRITE;
  wire  [1:0]  SIZE;
  logic        ackd_n;
  logic        ddt_en;
  logic [31:0] ddt_val;
  wire  [31:0] DDT;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] HIZ = 32'hFFFF_FFFF;

  always #5 clk = ~clk;

  assign DDT = ddt_en ? ddt_val : 32'bz;
  pullup (DDT);

  data_bus_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .i_req(i_req), .i_write(i_write), .i_size(i_size),
    .i_signed(i_signed), .i_addr(i_addr), .i_wdata(i_wdata), .o_stall(o_stall),
    .o_done(o_done), .o_err(o_err), .o_rdata(o_rdata), .DAD(DAD), .MREQ(MREQ),
    .WRITE(WRITE), .SIZE(SIZE), .ACKD_n(ackd_n), .DDT(DDT)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // exp is the expected DDT lanes for stores, expected o_rdata for loads.
  task automatic access(input string tag, input logic wr, input logic [1:0] sz,
                        input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] bus, input int waits, input logic mis,
                        input logic [31:0] exp);
    i_req = 1'b1; i_write = wr; i_size = sz; i_signed = sgn;
    i_addr = addr; i_wdata = wdata; ackd_n = 1'b1; ddt_en = 1'b0;
    #1;
    check({tag, ":stall_req"}, o_stall, 1);
    tick;
    if (mis) begin
      check({tag, ":mreq_mis"}, MREQ, 0);
      check({tag, ":done_mis"}, o_done, 1);
      check({tag, ":err_mis"}, o_err, 1);
      i_req = 1'b0;
      tick;
      check({tag, ":done_after"}, o_done, 0);
      return;
    end
    check({tag, ":mreq"}, MREQ, 1);
    check({tag, ":dad"}, DAD, addr);
    check({tag, ":size"}, SIZE, sz);
    check({tag, ":write"}, WRITE, wr);
    check({tag, ":done_bus"}, o_done, 0);
    check({tag, ":ddt_bus"}, DDT, wr ? exp : HIZ);
    i_req = 1'b0;
    for (int w = 0; w < waits; w++) begin
      tick;
      check({tag, ":mreq_wait"}, MREQ, 1);
      check({tag, ":stall_wait"}, o_stall, 1);
      check({tag, ":done_wait"}, o_done, 0);
    end
    ackd_n = 1'b0;
    if (!wr) begin
      ddt_en = 1'b1; ddt_val = bus;
    end
    tick;
    ddt_en = 1'b0;
    #1;
    check({tag, ":mreq_done"}, MREQ, 0);
    check({tag, ":write_done"}, WRITE, 0);
    check({tag, ":done"}, o_done, 1);
    check({tag, ":err"}, o_err, 0);
    check({tag, ":stall_done"}, o_stall, 0);
    if (!wr) check({tag, ":rdata"}, o_rdata, exp);
    else check({tag, ":ddt_released"}, DDT, HIZ);
    ackd_n = 1'b1;
    tick;
    check({tag, ":done_pulse"}, o_done, 0);
  endtask

  initial begin
    rst = 1'b0; i_req = 1'b0; i_write = 1'b0; i_size = 2'b00; i_signed = 1'b0;
    i_addr = '0; i_wdata = '0; ackd_n = 1'b1; ddt_en = 1'b0; ddt_val = '0;
    tick; tick;
    check("rst:mreq", MREQ, 0);
    check("rst:write", WRITE, 0);
    check("rst:size", SIZE, 0);
    check("rst:dad", DAD, 0);
    check("rst:done", o_done, 0);
    check("rst:err", o_err, 0);
    check("rst:rdata", o_rdata, 0);
    check("rst:ddt", DDT, HIZ);
    check("rst:stall", o_stall, 0);
    rst = 1'b1;
    tick;

    // Ack outside a bus cycle must not start or finish anything.
    ackd_n = 1'b0;
    tick; tick;
    check("idle_ack:mreq", MREQ, 0);
    check("idle_ack:done", o_done, 0);
    ackd_n = 1'b1;
    tick;

    access("ld_word",   1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 1'b0, 32'hDEAD_BEEF);
    access("ld_sbyte",  1'b0, 2'b10, 1'b1, 32'h103, 32'h0, 32'h80FF_FFFF, 3, 1'b0, 32'hFFFF_FF80);
    access("ld_ubyte",  1'b0, 2'b10, 1'b0, 32'h103, 32'h0, 32'h80FF_FFFF, 3, 1'b0, 32'h0000_0080);
    access("ld_shalf",  1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'h8001_1234, 1, 1'b0, 32'hFFFF_8001);
    access("ld_uhalf",  1'b0, 2'b01, 1'b0, 32'h100, 32'h0, 32'h1234_F00D, 0, 1'b0, 32'h0000_F00D);
    access("ld_shalf0", 1'b0, 2'b01, 1'b1, 32'h100, 32'h0, 32'h1234_F00D, 2, 1'b0, 32'hFFFF_F00D);
    access("ld_ubyte1", 1'b0, 2'b10, 1'b1, 32'h101, 32'h0, 32'h0000_7F00, 0, 1'b0, 32'h0000_007F);
    access("st_half",   1'b1, 2'b01, 1'b0, 32'h202, 32'h0000_ABCD, 32'h0, 1, 1'b0, 32'hABCD_ABCD);
    access("st_byte",   1'b1, 2'b10, 1'b0, 32'h001, 32'h1234_5678, 32'h0, 0, 1'b0, 32'h7878_7878);
    access("st_word",   1'b1, 2'b00, 1'b0, 32'h204, 32'hCAFE_F00D, 32'h0, 2, 1'b0, 32'hCAFE_F00D);
    access("mis_word",  1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 32'h0, 0, 1'b1, 32'h0);
    access("mis_half",  1'b1, 2'b01, 1'b0, 32'h203, 32'h0, 32'h0, 0, 1'b1, 32'h0);
    access("mis_dword", 1'b0, 2'b11, 1'b0, 32'h000, 32'h0, 32'h0, 0, 1'b1, 32'h0);

    // Bus that never acknowledges.
    i_req = 1'b1; i_write = 1'b0; i_size = 2'b00; i_signed = 1'b0; i_addr = 32'h300;
    ackd_n = 1'b1;
    tick;
`ifdef DBU_TIMEOUT_EN
    for (int c = 1; c <= 4; c++) begin
      check("tmo:mreq_wait", MREQ, 1);
      check("tmo:done_wait", o_done, 0);
      i_req = 1'b0;
      tick;
    end
    check("tmo:mreq", MREQ, 0);
    check("tmo:done", o_done, 1);
    check("tmo:err", o_err, 1);
    check("tmo:rdata", o_rdata, 0);
    tick;
    check("tmo:done_pulse", o_done, 0);
`else
    i_req = 1'b0;
    repeat (20) tick;
    check("no_tmo:mreq", MREQ, 1);
    check("no_tmo:done", o_done, 0);
    check("no_tmo:stall", o_stall, 1);
    rst = 1'b0;
    tick;
    rst = 1'b1;
    check("no_tmo:mreq_rst", MREQ, 0);
    tick;
`endif

    // Reset in the middle of a store bus cycle.
    i_req = 1'b1; i_write = 1'b1; i_size = 2'b00; i_addr = 32'h400; i_wdata = 32'h55AA_55AA;
    tick;
    check("rst_bus:mreq", MREQ, 1);
    check("rst_bus:ddt", DDT, 32'h55AA_55AA);
    rst = 1'b0; i_req = 1'b0;
    tick;
    check("rst_bus:mreq_after", MREQ, 0);
    check("rst_bus:ddt_after", DDT, HIZ);
    check("rst_bus:done_after", o_done, 0);
    rst = 1'b1;
    tick;
    check("rst_bus:done_late", o_done, 0);
    check("rst_bus:err_late", o_err, 0);

    access("post_rst", 1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 32'h0123_4567, 1, 1'b0, 32'h0123_4567);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
